time_jump_sequencer: RTL and testbench
======================================

Name: time_jump_sequencer

Overview:
- Stage directly downstream of the ship-loading stage.
- Consumes the loader's 3-bit next-state code and a launch request.
- Sequences fuelling, launch countdown and a single-cycle jump fire, then returns to idle.
- Raises a sticky fault when the loader reports not-loaded (3'b111) or loses loaded status mid-sequence.

Parameters:
FUEL_W, 4, width of fuel accumulator and fuel_units
FUEL_REQ, 4'd12, fuel level required to leave FUEL
COUNT_W, 4, width of countdown counter
COUNT_START, 4'd10, countdown load value

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous active-low reset
load_state  in  3  loader next-state code: 3'b010 = loaded, 3'b111 = not loaded
launch_req  in  1  level request to begin launch sequence
abort  in  1  abort / fault acknowledge
fuel_valid  in  1  fuel_units valid this cycle
fuel_units  in  FUEL_W  fuel added when fuel_valid
state_out  out  3  current state code
fuel_level  out  FUEL_W  accumulated fuel
countdown  out  COUNT_W  current countdown value
jump_fire  out  1  one-cycle jump pulse
busy  out  1  high in FUEL, COUNT, JUMP
fault  out  1  high in FAULT

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset_n=0 at edge): state IDLE, fuel_level=0, countdown=0, jump_fire=0, busy=0, fault=0.
- Reset mid-sequence behaves identically; no jump pulse is emitted.
- All outputs are registered. busy and fault decode the registered state.
- State codes: IDLE=3'b001, FUEL=3'b011, COUNT=3'b100, JUMP=3'b101, FAULT=3'b111.
- IDLE:
  - launch_req & load_state==010 -> FUEL.
  - launch_req & load_state!=010 -> FAULT.
  - Otherwise stay in IDLE.
- FUEL:
  - Each fuel_valid cycle: fuel_level <= saturating add of fuel_units. Clamps at 2^FUEL_W-1; no wrap.
  - Exit test uses the registered fuel_level: fuel_level>=FUEL_REQ -> COUNT, countdown<=COUNT_START. Fuel arriving in the exit cycle is still added.
- COUNT:
  - countdown decrements by 1 each cycle.
  - In the cycle countdown==0 -> JUMP.
  - COUNT lasts COUNT_START+1 cycles; countdown never wraps.
- JUMP:
  - Exactly one cycle; jump_fire=1 registered with the state.
  - On exit fuel_level<=0, countdown<=0 -> IDLE.
  - abort and load_state are ignored in JUMP (jump committed).
- abort in FUEL or COUNT -> IDLE next cycle:
  - countdown<=0; fuel_level retained.
  - abort beats fuel_valid in the same cycle (fuel discarded).
  - abort beats a loaded-status drop in the same cycle (go to IDLE, not FAULT).
- load_state leaves 010 during FUEL or COUNT (and abort=0) -> FAULT, countdown<=0.
- FAULT is sticky:
  - Exits to IDLE only on abort=1. fault drops the cycle after.
  - launch_req is ignored while in FAULT.
- launch_req is level-sensitive. If it is still high when IDLE is re-entered after JUMP, a new sequence starts the next cycle.

Decomposition:
- Shared package:
  - State code constants (shared with the rest/load stages; 3'b010 and 3'b111 must match the loader).
  - FUEL_REQ and COUNT_START defaults.
- Sub-module fuel_sat_adder:
  - FUEL_W ripple chain built from the existing full-adder cell.
  - Carry-out selects all-ones (saturation).
- Next-state logic and the countdown decrementer stay in the top module.

Test Plan:
- Reset then launch_req=1, load_state=010, fuel_units=4 every cycle -> fuel_level 4,8,12; COUNT entered with countdown=10; jump_fire high 11 cycles after COUNT entry; fuel_level=0 and state 001 afterwards.
- In IDLE: launch_req=1, load_state=111 -> state 111, fault=1. Hold launch_req with abort=0 -> stays FAULT. abort=1 -> state 001, fault=0.
- In FUEL with fuel_level=12: fuel_valid=1, fuel_units=15 -> fuel_level saturates at 15 (no wrap to 11). The exit test uses the prior value 12, so COUNT is entered the same cycle.
- abort at countdown=5 with fuel_level=12 -> IDLE; countdown=0; fuel_level stays 12; no jump_fire.
- load_state changes 010->000 at countdown=3 -> FAULT, countdown=0, jump_fire never asserts.
- reset_n=0 for one cycle while in COUNT -> all outputs zero, state 001. Repeat with abort=1 in the JUMP cycle -> jump_fire still pulses exactly once.

Source files
------------

// File: rtl/time_jump_sequencer_pkg.sv
// Shared codes and defaults for the jump sequencer stage.
// Loader codes must match the ship-loading stage exactly.
package time_jump_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_FUEL  = 3'b011,
        ST_COUNT = 3'b100,
        ST_JUMP  = 3'b101,
        ST_FAULT = 3'b111
    } state_e;

    localparam logic [2:0] LOAD_LOADED = 3'b010;
    localparam logic [2:0] LOAD_EMPTY  = 3'b111;

    localparam logic [3:0] FUEL_REQ_DEF    = 4'd12;
    localparam logic [3:0] COUNT_START_DEF = 4'd10;

    // Full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        full_add = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/time_jump_sequencer_fuel_sat_adder.sv
// Ripple-carry adder from full-adder cells; a carry out clamps the sum to all-ones.
module fuel_sat_adder
    import time_jump_sequencer_pkg::*;
#(
    parameter int FUEL_W = 4
) (
    input  logic [FUEL_W-1:0] i_a,
    input  logic [FUEL_W-1:0] i_b,
    output logic [FUEL_W-1:0] o_sum
);
    logic [FUEL_W:0]   w_c;
    logic [FUEL_W-1:0] w_s;

    assign w_c[0] = 1'b0;

    for (genvar g = 0; g < FUEL_W; g++) begin : g_fa
        assign {w_c[g+1], w_s[g]} = full_add(i_a[g], i_b[g], w_c[g]);
    end

    assign o_sum = w_c[FUEL_W] ? {FUEL_W{1'b1}} : w_s;

endmodule

// File: rtl/time_jump_sequencer.sv
// Fuel / countdown / jump-fire sequencer fed by the loader's next-state code.
// FAULT is sticky until abort; JUMP is committed and ignores abort and loader status.
module time_jump_sequencer
    import time_jump_sequencer_pkg::*;
#(
    parameter int                 FUEL_W      = 4,
    parameter logic [FUEL_W-1:0]  FUEL_REQ    = FUEL_REQ_DEF,
    parameter int                 COUNT_W     = 4,
    parameter logic [COUNT_W-1:0] COUNT_START = COUNT_START_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         load_state,
    input  logic               launch_req,
    input  logic               abort,
    input  logic               fuel_valid,
    input  logic [FUEL_W-1:0]  fuel_units,
    output logic [2:0]         state_out,
    output logic [FUEL_W-1:0]  fuel_level,
    output logic [COUNT_W-1:0] countdown,
    output logic               jump_fire,
    output logic               busy,
    output logic               fault
);
    state_e             r_state, w_nstate;
    logic [FUEL_W-1:0]  r_fuel, w_nfuel, w_fuel_sum;
    logic [COUNT_W-1:0] r_count, w_ncount;
    logic               w_loaded;

    assign w_loaded = (load_state == LOAD_LOADED);

    fuel_sat_adder #(.FUEL_W(FUEL_W)) u_add (
        .i_a  (r_fuel),
        .i_b  (fuel_units),
        .o_sum(w_fuel_sum)
    );

    always_comb begin
        w_nstate = r_state;
        w_nfuel  = r_fuel;
        w_ncount = r_count;
        unique case (r_state)
            ST_IDLE: begin
                if (launch_req) w_nstate = w_loaded ? ST_FUEL : ST_FAULT;
            end
            ST_FUEL, ST_COUNT: begin
                if (abort) begin
                    w_nstate = ST_IDLE;
                    w_ncount = '0;
                end else if (!w_loaded) begin
                    w_nstate = ST_FAULT;
                    w_ncount = '0;
                end else if (r_state == ST_FUEL) begin
                    if (fuel_valid) w_nfuel = w_fuel_sum;
                    // Exit decision uses the level before this cycle's fuel lands.
                    if (r_fuel >= FUEL_REQ) begin
                        w_nstate = ST_COUNT;
                        w_ncount = COUNT_START;
                    end
                end else if (r_count == '0) begin
                    w_nstate = ST_JUMP;
                end else begin
                    w_ncount = r_count - COUNT_W'(1);
                end
            end
            ST_JUMP: begin
                w_nstate = ST_IDLE;
                w_nfuel  = '0;
                w_ncount = '0;
            end
            ST_FAULT: begin
                if (abort) w_nstate = ST_IDLE;
            end
            default: w_nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_fuel  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_nstate;
            r_fuel  <= w_nfuel;
            r_count <= w_ncount;
        end
    end

    assign state_out  = r_state;
    assign fuel_level = r_fuel;
    assign countdown  = r_count;
    assign jump_fire  = (r_state == ST_JUMP);
    assign busy       = (r_state == ST_FUEL) || (r_state == ST_COUNT) || (r_state == ST_JUMP);
    assign fault      = (r_state == ST_FAULT);

endmodule

// File: tb/tb_time_jump_sequencer.sv
// Directed bench for time_jump_sequencer with hand-computed expectations.
module tb_time_jump_sequencer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] load_state;
    logic       launch_req, abort, fuel_valid;
    logic [3:0] fuel_units;
    logic [2:0] state_out;
    logic [3:0] fuel_level, countdown;
    logic       jump_fire, busy, fault;

    int total = 0;
    int bad   = 0;
    int jf_cnt;

    always #5 clk = ~clk;

    time_jump_sequencer dut (
        .clk(clk), .reset_n(reset_n), .load_state(load_state), .launch_req(launch_req),
        .abort(abort), .fuel_valid(fuel_valid), .fuel_units(fuel_units),
        .state_out(state_out), .fuel_level(fuel_level), .countdown(countdown),
        .jump_fire(jump_fire), .busy(busy), .fault(fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset_n = 1'b1; load_state = 3'b010; launch_req = 1'b0; abort = 1'b0;
        fuel_valid = 1'b0; fuel_units = 4'd0;
    endtask

    // Reset, then launch and fuel with 4,4,4 so COUNT is entered with fuel 12, countdown 10.
    task automatic go_count();
        idle_inputs(); reset_n = 1'b0; step(); reset_n = 1'b1;
        launch_req = 1'b1; step();
        launch_req = 1'b0; fuel_valid = 1'b1; fuel_units = 4'd4;
        repeat (3) step();
        fuel_valid = 1'b0; step();
    endtask

    task automatic test_reset();
        idle_inputs(); reset_n = 1'b0; step(); reset_n = 1'b1;
        total++; if (state_out !== 3'b001) begin bad++; $display("FAIL reset_state got=%b want=001", state_out); end
        total++; if ({fuel_level, countdown, jump_fire, busy, fault} !== 11'd0) begin bad++;
            $display("FAIL reset_outputs got fuel=%0d cnt=%0d jf=%b busy=%b fault=%b want all 0", fuel_level, countdown, jump_fire, busy, fault); end
    endtask

    task automatic test_nominal();
        idle_inputs(); launch_req = 1'b1; fuel_valid = 1'b1; fuel_units = 4'd4;
        step();
        total++; if (state_out !== 3'b011 || busy !== 1'b1 || fuel_level !== 4'd0) begin bad++;
            $display("FAIL nom_fuel_entry got st=%b busy=%b fuel=%0d want 011/1/0", state_out, busy, fuel_level); end
        launch_req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (fuel_level !== 4'(4*i) || state_out !== 3'b011) begin bad++;
                $display("FAIL nom_fuel_acc got fuel=%0d st=%b want %0d/011", fuel_level, state_out, 4*i); end
        end
        step();
        total++; if (state_out !== 3'b100 || countdown !== 4'd10 || fuel_level !== 4'd15) begin bad++;
            $display("FAIL nom_count_entry got st=%b cnt=%0d fuel=%0d want 100/10/15", state_out, countdown, fuel_level); end
        fuel_valid = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            step();
            total++; if (countdown !== 4'(i) || state_out !== 3'b100 || jump_fire !== 1'b0) begin bad++;
                $display("FAIL nom_countdown got cnt=%0d st=%b jf=%b want %0d/100/0", countdown, state_out, jump_fire, i); end
        end
        step();
        total++; if (state_out !== 3'b101 || jump_fire !== 1'b1 || busy !== 1'b1) begin bad++;
            $display("FAIL nom_jump got st=%b jf=%b busy=%b want 101/1/1", state_out, jump_fire, busy); end
        step();
        total++; if (state_out !== 3'b001 || jump_fire !== 1'b0 || fuel_level !== 4'd0 || countdown !== 4'd0) begin bad++;
            $display("FAIL nom_return got st=%b jf=%b fuel=%0d cnt=%0d want 001/0/0/0", state_out, jump_fire, fuel_level, countdown); end
    endtask

    task automatic test_fault();
        idle_inputs(); launch_req = 1'b1; load_state = 3'b111;
        step();
        total++; if (state_out !== 3'b111 || fault !== 1'b1 || busy !== 1'b0) begin bad++;
            $display("FAIL flt_enter got st=%b fault=%b busy=%b want 111/1/0", state_out, fault, busy); end
        load_state = 3'b010; repeat (3) step();
        total++; if (state_out !== 3'b111 || fault !== 1'b1) begin bad++;
            $display("FAIL flt_sticky got st=%b fault=%b want 111/1", state_out, fault); end
        launch_req = 1'b0; abort = 1'b1; step(); abort = 1'b0;
        total++; if (state_out !== 3'b001 || fault !== 1'b0) begin bad++;
            $display("FAIL flt_clear got st=%b fault=%b want 001/0", state_out, fault); end
        step();
        total++; if (state_out !== 3'b001) begin bad++; $display("FAIL flt_stay_idle got st=%b want 001", state_out); end
    endtask

    task automatic test_saturate();
        idle_inputs(); reset_n = 1'b0; step(); reset_n = 1'b1;
        launch_req = 1'b1; step(); launch_req = 1'b0;
        fuel_valid = 1'b1; fuel_units = 4'd4; repeat (3) step();
        total++; if (fuel_level !== 4'd12 || state_out !== 3'b011) begin bad++;
            $display("FAIL sat_pre got fuel=%0d st=%b want 12/011", fuel_level, state_out); end
        fuel_units = 4'd15; step(); fuel_valid = 1'b0;
        total++; if (fuel_level !== 4'd15 || state_out !== 3'b100 || countdown !== 4'd10) begin bad++;
            $display("FAIL sat_clamp got fuel=%0d st=%b cnt=%0d want 15/100/10", fuel_level, state_out, countdown); end
    endtask

    task automatic test_abort();
        // abort beats fuel_valid in FUEL
        idle_inputs(); reset_n = 1'b0; step(); reset_n = 1'b1;
        launch_req = 1'b1; step(); launch_req = 1'b0;
        fuel_valid = 1'b1; fuel_units = 4'd4; step();
        abort = 1'b1; load_state = 3'b000; step(); abort = 1'b0; fuel_valid = 1'b0; load_state = 3'b010;
        total++; if (state_out !== 3'b001 || fuel_level !== 4'd4) begin bad++;
            $display("FAIL abt_fuel got st=%b fuel=%0d want 001/4", state_out, fuel_level); end
        go_count();
        repeat (5) step();
        total++; if (countdown !== 4'd5 || state_out !== 3'b100) begin bad++;
            $display("FAIL abt_pre got cnt=%0d st=%b want 5/100", countdown, state_out); end
        abort = 1'b1; step(); abort = 1'b0;
        jf_cnt = 0;
        total++; if (state_out !== 3'b001 || countdown !== 4'd0 || fuel_level !== 4'd12) begin bad++;
            $display("FAIL abt_count got st=%b cnt=%0d fuel=%0d want 001/0/12", state_out, countdown, fuel_level); end
        repeat (12) begin step(); if (jump_fire) jf_cnt++; end
        total++; if (jf_cnt !== 0) begin bad++; $display("FAIL abt_nojump got pulses=%0d want 0", jf_cnt); end
    endtask

    task automatic test_load_drop();
        go_count();
        repeat (7) step();
        load_state = 3'b000; step();
        total++; if (state_out !== 3'b111 || countdown !== 4'd0 || fault !== 1'b1) begin bad++;
            $display("FAIL drop_fault got st=%b cnt=%0d fault=%b want 111/0/1", state_out, countdown, fault); end
        jf_cnt = 0;
        repeat (12) begin step(); if (jump_fire) jf_cnt++; end
        total++; if (jf_cnt !== 0 || state_out !== 3'b111) begin bad++;
            $display("FAIL drop_nojump got pulses=%0d st=%b want 0/111", jf_cnt, state_out); end
        abort = 1'b1; step(); abort = 1'b0; load_state = 3'b010;
    endtask

    task automatic test_reset_mid();
        go_count();
        repeat (2) step();
        reset_n = 1'b0; step(); reset_n = 1'b1;
        total++; if (state_out !== 3'b001 || {fuel_level, countdown, jump_fire, busy, fault} !== 11'd0) begin bad++;
            $display("FAIL rst_mid got st=%b fuel=%0d cnt=%0d jf=%b want 001/0/0/0", state_out, fuel_level, countdown, jump_fire); end
        go_count();
        repeat (10) step();
        total++; if (countdown !== 4'd0 || state_out !== 3'b100) begin bad++;
            $display("FAIL jab_pre got cnt=%0d st=%b want 0/100", countdown, state_out); end
        jf_cnt = 0;
        step(); if (jump_fire) jf_cnt++;
        abort = 1'b1; load_state = 3'b000; step(); if (jump_fire) jf_cnt++;
        abort = 1'b0; load_state = 3'b010;
        total++; if (state_out !== 3'b001 || fuel_level !== 4'd0) begin bad++;
            $display("FAIL jab_exit got st=%b fuel=%0d want 001/0", state_out, fuel_level); end
        repeat (3) begin step(); if (jump_fire) jf_cnt++; end
        total++; if (jf_cnt !== 1) begin bad++; $display("FAIL jab_pulse got pulses=%0d want 1", jf_cnt); end
    endtask

    task automatic test_back_to_back();
        go_count();
        launch_req = 1'b1; repeat (12) step();
        total++; if (state_out !== 3'b001) begin bad++; $display("FAIL b2b_idle got st=%b want 001", state_out); end
        step(); launch_req = 1'b0;
        total++; if (state_out !== 3'b011 || fuel_level !== 4'd0) begin bad++;
            $display("FAIL b2b_restart got st=%b fuel=%0d want 011/0", state_out, fuel_level); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_nominal();
        test_fault();
        test_saturate();
        test_abort();
        test_load_drop();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
